// File: rtl/writeback_stage_if.sv
// Retire handshake between the memory stage and the writeback stage.
//   m_valid      : memory stage presents a retiring instruction
//   m_ready      : writeback stage can accept an instruction this cycle
//   m_reg_write  : instruction writes a register
//   m_mem_to_reg : result comes from data memory (load)
//   m_write_reg  : destination register
//   m_alu_result : ALU result (non-load write data)
// master = memory stage side, slave = writeback stage side.
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              m_valid;
  logic              m_ready;
  logic              m_reg_write;
  logic              m_mem_to_reg;
  logic [REG_AW-1:0] m_write_reg;
  logic [DATA_W-1:0] m_alu_result;

  modport master (
    output m_valid, m_reg_write, m_mem_to_reg, m_write_reg, m_alu_result,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_reg_write, m_mem_to_reg, m_write_reg, m_alu_result,
    output m_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage. Accepts retiring instructions over the m_* handshake,
// waits for data-memory read data on loads, and drives the register-file
// write port. Also exports forwarding/hazard info and a retired counter.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   m (slave)               : retire handshake from the memory stage
//   dmem_rvalid, dmem_rdata : data-memory read response (one-cycle pulse)
//   write_enabled/reg/data  : register-file write port
//   fwd_valid/reg/data      : held committable result for forwarding
//   load_pending            : held load still waiting for memory data
//   retired_count           : committed instruction count (wraps)
//   resp_err                : sticky, read data arrived with no load outstanding
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  m,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              write_enabled,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_pending,
  output logic [CNT_W-1:0]  retired_count,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_COMMIT    = 2'd2
  } state_t;

  state_t            state;
  logic              h_reg_write;
  logic [REG_AW-1:0] h_write_reg;
  logic [DATA_W-1:0] h_data;
  logic              accept;
  logic              commit_wr;

  // Ready is gated by rst so it reads 0 while reset is held even though the
  // state register already sits in IDLE.
  assign m.m_ready = !rst && ((state == S_IDLE) || (state == S_COMMIT));
  assign accept    = m.m_valid && m.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      h_reg_write   <= 1'b0;
      h_write_reg   <= '0;
      h_data        <= '0;
      retired_count <= '0;
      resp_err      <= 1'b0;
    end else begin
      case (state)
        S_LOAD_WAIT: begin
          if (dmem_rvalid) begin
            h_data <= dmem_rdata;
            state  <= S_COMMIT;
          end
        end
        default: begin
          // IDLE and COMMIT behave alike except that COMMIT retires the held
          // instruction; a new accept overwrites the held fields at this edge.
          if (state == S_COMMIT) retired_count <= retired_count + 1'b1;
          if (dmem_rvalid) resp_err <= 1'b1;
          if (accept) begin
            h_reg_write <= m.m_reg_write;
            h_write_reg <= m.m_write_reg;
            h_data      <= m.m_alu_result;
            state       <= m.m_mem_to_reg ? S_LOAD_WAIT : S_COMMIT;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign commit_wr     = (state == S_COMMIT) && h_reg_write && (h_write_reg != '0);
  assign write_enabled = commit_wr;
  assign write_reg     = (state != S_IDLE) ? h_write_reg : '0;
  assign write_data    = (state != S_IDLE) ? h_data      : '0;
  assign fwd_valid     = commit_wr;
  assign fwd_reg       = write_reg;
  assign fwd_data      = write_data;
  assign load_pending  = (state == S_LOAD_WAIT) && h_reg_write;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) mif ();
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              write_enabled, fwd_valid, load_pending, resp_err;
  logic [REG_AW-1:0] write_reg, fwd_reg;
  logic [DATA_W-1:0] write_data, fwd_data;
  logic [CNT_W-1:0]  retired_count;

  writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .m(mif.slave),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .write_enabled(write_enabled), .write_reg(write_reg), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .load_pending(load_pending), .retired_count(retired_count), .resp_err(resp_err)
  );

  // Narrow-counter instance used only for the wrap check.
  writeback_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) wif ();
  logic              w_we, w_fv, w_lp, w_err;
  logic [REG_AW-1:0] w_wr, w_fr;
  logic [DATA_W-1:0] w_wd, w_fd;
  logic [3:0]        w_cnt;

  writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .m(wif.slave),
    .dmem_rvalid(1'b0), .dmem_rdata('0),
    .write_enabled(w_we), .write_reg(w_wr), .write_data(w_wd),
    .fwd_valid(w_fv), .fwd_reg(w_fr), .fwd_data(w_fd),
    .load_pending(w_lp), .retired_count(w_cnt), .resp_err(w_err)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [REG_AW-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every register-file write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && write_enabled) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", write_reg, write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (write_reg !== e.r || write_data !== e.d || !fwd_valid ||
            fwd_reg !== e.r || fwd_data !== e.d) begin
          n_err++;
          $display("FAIL write_port: got r%0d=0x%0h fwd(%0b,r%0d,0x%0h) expected r%0d=0x%0h",
                   write_reg, write_data, fwd_valid, fwd_reg, fwd_data, e.r, e.d);
        end
      end
    end
  end

  // Presents one instruction and returns just after the edge that accepts it.
  // m_valid is left high so consecutive calls form back-to-back traffic.
  task automatic send(input logic rw, input logic m2r, input logic [REG_AW-1:0] r,
                      input logic [DATA_W-1:0] d);
    int unsigned guard;
    mif.m_valid      = 1'b1;
    mif.m_reg_write  = rw;
    mif.m_mem_to_reg = m2r;
    mif.m_write_reg  = r;
    mif.m_alu_result = d;
    guard = 0;
    @(negedge clk);
    while (!mif.m_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!mif.m_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got m_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int unsigned n);
    mif.m_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] cnt0;

  initial begin
    mif.m_valid = 0; mif.m_reg_write = 0; mif.m_mem_to_reg = 0;
    mif.m_write_reg = '0; mif.m_alu_result = '0;
    wif.m_valid = 0; wif.m_reg_write = 0; wif.m_mem_to_reg = 0;
    wif.m_write_reg = '0; wif.m_alu_result = '0;
    dmem_rvalid = 0; dmem_rdata = '0;

    // Reset state
    #12;
    check("rst_m_ready", mif.m_ready, 0);
    check("rst_write_enabled", write_enabled, 0);
    check("rst_count", retired_count, 0);
    check("rst_resp_err", resp_err, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_m_ready", mif.m_ready, 1);
    @(posedge clk); #1;

    // Back-to-back non-loads
    exp_q.push_back('{r: 5'd3, d: 32'h5});
    send(1, 0, 5'd3, 32'h5);
    exp_q.push_back('{r: 5'd4, d: 32'hA});
    send(1, 0, 5'd4, 32'hA);
    check("b2b_ready1", mif.m_ready, 1);
    exp_q.push_back('{r: 5'd5, d: 32'hF});
    send(1, 0, 5'd5, 32'hF);
    check("b2b_ready2", mif.m_ready, 1);
    idle_cycles(2);
    check("b2b_count", retired_count, 3);

    // Load to r8, data returns in the third waiting cycle
    send(1, 1, 5'd8, 32'h1111_1111);
    mif.m_valid = 0;
    exp_q.push_back('{r: 5'd8, d: 32'hDEAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      check("load_pending", load_pending, 1);
      check("load_m_ready", mif.m_ready, 0);
      check("load_no_write", write_enabled, 0);
      @(posedge clk); #1;
    end
    dmem_rvalid = 0; dmem_rdata = '0;
    @(negedge clk);
    check("load_commit_we", write_enabled, 1);
    check("load_pending_clr", load_pending, 0);
    idle_cycles(2);
    check("load_count", retired_count, 4);

    // r0 write and store: retire without any write strobe
    cnt0 = retired_count;
    send(1, 0, 5'd0, 32'h1234);
    send(0, 0, 5'd7, 32'h55);
    @(negedge clk);
    check("r0_store_fwd_valid", fwd_valid, 0);
    idle_cycles(2);
    check("r0_store_count", retired_count, cnt0 + 2);

    // Stray read data while IDLE
    @(posedge clk); #1 dmem_rvalid = 1; dmem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1 dmem_rvalid = 0;
    check("resp_err_set", resp_err, 1);
    idle_cycles(3);
    check("resp_err_sticky", resp_err, 1);
    send(1, 1, 5'd9, 32'h0);
    mif.m_valid = 0;
    exp_q.push_back('{r: 5'd9, d: 32'hCAFE_F00D});
    @(posedge clk); #1 dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1 dmem_rvalid = 0;
    idle_cycles(2);
    check("resp_err_load_count", retired_count, 7);

    // Reset in the middle of LOAD_WAIT, asserted between edges
    send(1, 1, 5'd8, 32'h0);
    mif.m_valid = 0;
    @(posedge clk); #2 rst = 1;
    #1;
    check("midrst_load_pending", load_pending, 0);
    check("midrst_write_reg", write_reg, 0);
    check("midrst_m_ready", mif.m_ready, 0);
    check("midrst_count", retired_count, 0);
    check("midrst_resp_err", resp_err, 0);
    @(negedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst_ready_after", mif.m_ready, 1);
    idle_cycles(4);
    check("midrst_count_after", retired_count, 0);

    // Counter wrap on the 4-bit instance
    wif.m_valid = 1;
    repeat (15) @(posedge clk);
    #1 wif.m_valid = 0;
    repeat (2) @(posedge clk);
    #1 check("wrap_count15", w_cnt, 15);
    wif.m_valid = 1;
    @(posedge clk); #1 wif.m_valid = 0;
    repeat (2) @(posedge clk);
    #1 check("wrap_count0", w_cnt, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
